// File: rtl/alu_issue.sv
// alu_issue: operand-issue stage in front of the 16-bit ALU.
// Decodes one instruction per cycle, reads operands from an 8x16 register
// file with writeback forwarding, tracks outstanding destinations in a
// per-register pending scoreboard, and holds registered ALU operands until
// the downstream consumer takes them.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [2:0]  alu_op,
    output logic [3:0]  alu_logic_func,
    output logic [15:0] alu_ina,
    output logic [15:0] alu_inb,
    output logic [15:0] alu_inc,
    output logic [2:0]  alu_rd,
    input  logic        wb_valid,
    input  logic [2:0]  wb_addr,
    input  logic [15:0] wb_data
);

    localparam logic [2:0] OP_LOGIC = 3'b100;

    // Architectural state
    logic [15:0] r_regs [8];
    logic [7:0]  r_pending;

    // Registered ALU-facing outputs
    logic        r_out_valid;
    logic [2:0]  r_alu_op;
    logic [3:0]  r_alu_logic_func;
    logic [15:0] r_alu_ina;
    logic [15:0] r_alu_inb;
    logic [15:0] r_alu_inc;
    logic [2:0]  r_alu_rd;

    // Decoded instruction fields
    logic [2:0]  w_op;
    logic [2:0]  w_rd;
    logic [2:0]  w_ra;
    logic [2:0]  w_rb;
    logic [3:0]  w_func;
    logic        w_is_logic;
    logic        w_use_imm;
    logic        w_rb_used;

    // Forwarded source reads and their effective pending state
    logic        w_fwd_ra;
    logic        w_fwd_rb;
    logic        w_fwd_rd;
    logic [15:0] w_ra_data;
    logic [15:0] w_rb_data;
    logic [15:0] w_rd_data;
    logic        w_ra_pend;
    logic        w_rb_pend;
    logic        w_rd_pend;

    logic [15:0] w_imm_sext;
    logic [15:0] w_inb;
    logic [3:0]  w_logic_func;
    logic        w_hazard;
    logic        w_ready;
    logic        w_accept;

    // Split the instruction word into its fields
    always_comb begin
        w_op       = in_instr[15:13];
        w_rd       = in_instr[12:10];
        w_ra       = in_instr[9:7];
        w_rb       = in_instr[6:4];
        w_func     = in_instr[3:0];
        w_is_logic = (w_op == OP_LOGIC);
        w_use_imm  = !w_is_logic && in_instr[3];
        w_rb_used  = !w_use_imm;
        w_imm_sext = {{13{in_instr[2]}}, in_instr[2:0]};
    end

    // Read sources, substituting same-cycle writeback data; a forwarded
    // source is resolved this cycle and therefore no longer pending
    always_comb begin
        w_fwd_ra  = wb_valid && (wb_addr == w_ra);
        w_fwd_rb  = wb_valid && (wb_addr == w_rb);
        w_fwd_rd  = wb_valid && (wb_addr == w_rd);
        w_ra_data = w_fwd_ra ? wb_data : r_regs[w_ra];
        w_rb_data = w_fwd_rb ? wb_data : r_regs[w_rb];
        w_rd_data = w_fwd_rd ? wb_data : r_regs[w_rd];
        w_ra_pend = r_pending[w_ra] && !w_fwd_ra;
        w_rb_pend = r_pending[w_rb] && !w_fwd_rb;
        w_rd_pend = r_pending[w_rd] && !w_fwd_rd;
    end

    // Select operand B and the logic truth table
    always_comb begin
        w_inb        = w_use_imm ? w_imm_sext : w_rb_data;
        w_logic_func = w_is_logic ? w_func : 4'b0000;
    end

    // Hazard detection and handshake; rd pending covers both the inc read and WAW
    always_comb begin
        w_hazard = w_ra_pend || (w_rb_used && w_rb_pend) || w_rd_pend;
        w_ready  = !w_hazard && (!r_out_valid || out_ready);
        w_accept = in_valid && w_ready;
    end

    assign in_ready = w_ready;

    // Register file: writeback lands every cycle it is strobed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 8; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_valid) begin
            r_regs[wb_addr] <= wb_data;
        end
    end

    // Scoreboard: writeback clears, accept sets; set wins on the same register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
        end else begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (w_accept && (w_rd == 3'(i))) begin
                    r_pending[i] <= 1'b1;
                end else if (wb_valid && (wb_addr == 3'(i))) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // Output valid: set on accept, cleared when consumed without a replacement
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
        end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // Operand registers load only on accept, so held operands ignore later writebacks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_op         <= '0;
            r_alu_logic_func <= '0;
            r_alu_ina        <= '0;
            r_alu_inb        <= '0;
            r_alu_inc        <= '0;
            r_alu_rd         <= '0;
        end else if (w_accept) begin
            r_alu_op         <= w_op;
            r_alu_logic_func <= w_logic_func;
            r_alu_ina        <= w_ra_data;
            r_alu_inb        <= w_inb;
            r_alu_inc        <= w_rd_data;
            r_alu_rd         <= w_rd;
        end
    end

    assign out_valid      = r_out_valid;
    assign alu_op         = r_alu_op;
    assign alu_logic_func = r_alu_logic_func;
    assign alu_ina        = r_alu_ina;
    assign alu_inb        = r_alu_inb;
    assign alu_inc        = r_alu_inc;
    assign alu_rd         = r_alu_rd;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed test-plan scenarios followed by randomized traffic,
// all checked against a cycle-level reference model of the issue stage.
module tb_alu_issue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  alu_op;
    logic [3:0]  alu_logic_func;
    logic [15:0] alu_ina;
    logic [15:0] alu_inb;
    logic [15:0] alu_inc;
    logic [2:0]  alu_rd;
    logic        wb_valid;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;

    int n_tests = 0;
    int n_fail  = 0;

    alu_issue dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .alu_op         (alu_op),
        .alu_logic_func (alu_logic_func),
        .alu_ina        (alu_ina),
        .alu_inb        (alu_inb),
        .alu_inc        (alu_inc),
        .alu_rd         (alu_rd),
        .wb_valid       (wb_valid),
        .wb_addr        (wb_addr),
        .wb_data        (wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_R [8];
    bit          m_P [8];
    bit          m_ov;
    logic [2:0]  m_op;
    logic [3:0]  m_lf;
    logic [15:0] m_ina;
    logic [15:0] m_inb;
    logic [15:0] m_inc;
    logic [2:0]  m_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_R[i] = '0;
            m_P[i] = 0;
        end
        m_ov = 0; m_op = '0; m_lf = '0; m_ina = '0; m_inb = '0; m_inc = '0; m_rd = '0;
    endtask

    task automatic check_outputs();
        check("out_valid", out_valid, m_ov);
        check("alu_op", alu_op, m_op);
        check("alu_logic_func", alu_logic_func, m_lf);
        check("alu_ina", alu_ina, m_ina);
        check("alu_inb", alu_inb, m_inb);
        check("alu_inc", alu_inc, m_inc);
        check("alu_rd", alu_rd, m_rd);
    endtask

    function automatic logic [15:0] mk(input int op, input int rd, input int ra, input int rb, input int imm);
        logic [15:0] w;
        w = 16'((op << 13) | (rd << 10) | (ra << 7) | (rb << 4) | imm);
        return w;
    endfunction

    // One clock cycle: inputs are already driven. The model applies the
    // writeback first (new register value, pending cleared), then decides
    // whether the instruction can issue from that resolved view.
    task automatic step();
        logic [15:0] nr [8];
        bit          np [8];
        int          op, rd, ra, rb;
        bit          use_imm, haz, exp_ready;
        nr = m_R;
        np = m_P;
        if (wb_valid) begin
            nr[wb_addr] = wb_data;
            np[wb_addr] = 0;
        end
        op = int'(in_instr[15:13]);
        rd = int'(in_instr[12:10]);
        ra = int'(in_instr[9:7]);
        rb = int'(in_instr[6:4]);
        use_imm = (op != 4) && in_instr[3];
        haz = np[ra] || (!use_imm && np[rb]) || np[rd];
        exp_ready = !haz && (!m_ov || out_ready);
        #1;
        check("in_ready", in_ready, exp_ready);
        @(posedge clk);
        if (in_valid && exp_ready) begin
            m_ov  = 1;
            m_op  = 3'(op);
            m_lf  = (op == 4) ? in_instr[3:0] : 4'd0;
            m_ina = nr[ra];
            m_inb = use_imm ? 16'(signed'(in_instr[2:0])) : nr[rb];
            m_inc = nr[rd];
            m_rd  = 3'(rd);
            np[rd] = 1;
        end else if (m_ov && out_ready) begin
            m_ov = 0;
        end
        m_R = nr;
        m_P = np;
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit v, input logic [15:0] ins, input bit ordy,
                         input bit wv, input int wa, input logic [15:0] wd);
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        wb_valid  = wv;
        wb_addr   = 3'(wa);
        wb_data   = wd;
    endtask

    initial begin
        int pend_list [$];
        rst = 1'b1;
        drive(0, 16'h0, 0, 0, 0, 16'h0);
        model_reset();
        #1;
        check_outputs();
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic issue with operands from the register file
        drive(0, 16'h0, 1, 1, 1, 16'h0010); step();
        drive(0, 16'h0, 1, 1, 2, 16'h0003); step();
        drive(1, mk(0, 3, 1, 2, 0), 1, 0, 0, 16'h0); step();
        check("tp_ina", alu_ina, 16'h0010);
        check("tp_inb", alu_inb, 16'h0003);
        check("tp_rd", alu_rd, 3);

        // RAW on r3 stalls until the resolving writeback, then forwards
        drive(1, mk(0, 4, 3, 2, 0), 1, 0, 0, 16'h0); step();
        check("tp_haz_stall", in_ready, 0);
        step();
        drive(1, mk(0, 4, 3, 2, 0), 1, 1, 3, 16'h1234); step();
        check("tp_fwd_ina", alu_ina, 16'h1234);

        // Immediate and logic operand selection
        drive(1, mk(2, 5, 1, 0, 4'b1110), 1, 0, 0, 16'h0); step();
        check("tp_imm_inb", alu_inb, 16'hFFFE);
        drive(1, mk(4, 6, 1, 2, 4'b0110), 1, 0, 0, 16'h0); step();
        check("tp_logic_func", alu_logic_func, 4'b0110);
        check("tp_logic_inb", alu_inb, 16'h0003);

        // Backpressure: operands held, writeback to source does not disturb them
        drive(1, mk(0, 7, 1, 2, 0), 0, 0, 0, 16'h0); step();
        drive(1, mk(0, 7, 1, 2, 0), 0, 1, 6, 16'h5555); step();
        drive(1, mk(0, 7, 1, 2, 0), 0, 1, 1, 16'hBEEF); step();
        check("tp_bp_hold_ina", alu_ina, 16'h0010);
        drive(1, mk(0, 7, 1, 2, 0), 1, 0, 0, 16'h0); step();
        check("tp_bp_release_ina", alu_ina, 16'hBEEF);
        drive(1, mk(2, 0, 2, 0, 4'b1001), 1, 0, 0, 16'h0); step();
        drive(0, 16'h0, 1, 0, 0, 16'h0); step();

        // Same-cycle writeback and accept on rd=5: ends pending, data written
        drive(1, mk(2, 5, 2, 0, 4'b1000), 1, 1, 5, 16'hA5A5); step();
        check("tp_same_inc", alu_inc, 16'hA5A5);
        drive(1, mk(0, 1, 5, 2, 0), 1, 0, 0, 16'h0); step();
        check("tp_same_pending", in_ready, 0);

        // Asynchronous reset while a result is held and registers are pending
        drive(1, mk(0, 1, 2, 2, 0), 0, 0, 0, 16'h0); step();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs();
        check("tp_rst_in_ready", in_ready, 1);
        drive(0, 16'h0, 0, 0, 0, 16'h0);
        #1;
        rst = 1'b0;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            bit          v, ordy, wv;
            int          wa;
            logic [15:0] ins;
            v    = ($urandom_range(0, 3) != 0);
            ins  = 16'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            wv   = ($urandom_range(0, 1) == 1);
            pend_list.delete();
            for (int i = 0; i < 8; i++) if (m_P[i]) pend_list.push_back(i);
            if (pend_list.size() > 0 && $urandom_range(0, 9) < 7)
                wa = pend_list[$urandom_range(0, pend_list.size() - 1)];
            else
                wa = int'($urandom_range(0, 7));
            drive(v, ins, ordy, wv, wa, 16'($urandom));
            if ($urandom_range(0, 599) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                model_reset();
                check_outputs();
                check("rand_rst_in_ready", in_ready, 1);
                #1;
                rst = 1'b0;
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Operand-issue stage directly upstream of the 16-bit ALU. Accepts one 16-bit instruction per cycle over a valid/ready handshake and reads operands from an internal 8×16 register file. Tracks outstanding destination writes with a scoreboard, stalling on hazards. Presents registered `op`/`logic_func`/`ina`/`inb`/`inc` to the ALU, and takes results back through a writeback port.

## Interface
- Parameters: none; widths fixed at 16-bit data, 8 registers, 3-bit register addresses.
- Ports:
  - `clk  in  1`: rising-edge clock.
  - `rst  in  1`: reset, asynchronous, active-high.
  - `in_valid  in  1`: instruction present.
  - `in_ready  out  1`: stage accepts the instruction this cycle.
  - `in_instr  in  16`: instruction word.
  - `out_valid  out  1`: ALU operands valid.
  - `out_ready  in  1`: downstream consumes the operands this cycle.
  - `alu_op  out  3`: ALU operation select.
  - `alu_logic_func  out  4`: truth table for op 3'b100.
  - `alu_ina  out  16`: operand A.
  - `alu_inb  out  16`: operand B.
  - `alu_inc  out  16`: condition operand.
  - `alu_rd  out  3`: destination tag travelling with the operands.
  - `wb_valid  in  1`: writeback strobe.
  - `wb_addr  in  3`: writeback register address.
  - `wb_data  in  16`: writeback data.

## Operation
- Instruction fields:
  - [15:13] op
  - [12:10] rd
  - [9:7] ra
  - [6:4] rb
  - [3:0] imm/func
- Operand A: `ina` = R[ra].
- Operand B:
  - op = 3'b100: `inb` = R[rb]; `logic_func` = instr[3:0].
  - Other ops: `logic_func` = 0. If instr[3]=1, `inb` = instr[2:0] sign-extended to 16 bits; otherwise `inb` = R[rb].
- Condition operand: `inc` = R[rd] for every op.
- Register file: no hardwired-zero register.
- Scoreboard: one `pending` bit per register.
  - Set for rd when an instruction is accepted.
  - Cleared for wb_addr when `wb_valid` is asserted.
- Writeback: `wb_valid` writes `wb_data` to R[wb_addr] every cycle it is asserted, regardless of the input handshake.
- Forwarding: a source read whose address equals `wb_addr` while `wb_valid`=1 takes `wb_data` and is treated as not pending.
- Hazard condition (stall), evaluated after forwarding:
  - R[ra] is pending, or
  - rb is used (op=3'b100, or instr[3]=0) and R[rb] is pending, or
  - R[rd] is pending. This covers both the `inc` read and WAW.
- `in_ready` = !hazard && (!out_valid || out_ready). It is combinational from `in_instr`, the scoreboard, the wb port and `out_ready`.
- Accept = `in_valid && in_ready`. On accept, all `alu_*` outputs and `alu_rd` load, and `out_valid` sets.
- Consume without accept: when `out_valid && out_ready` and there is no accept, `out_valid` clears and the operand registers hold their values.
- Held operands: while `out_valid && !out_ready`, all `alu_*` outputs are stable. Later writebacks do not alter them.
- Same-register wb and accept in one cycle: if `wb_addr` equals the accepted rd, the set wins and the bit ends pending. The write still updates R[rd].

## Timing
- Reset (asynchronous): all `alu_*` outputs, `alu_rd`, `out_valid`, all R[*] and all `pending` bits go to 0.
  - `in_ready` is 1 out of reset, provided `out_ready` is don't-care (`out_valid`=0).
  - Reset mid-stall drops the held instruction. No partial state survives.
- Latency: accept in cycle N → `out_valid`=1 with operands in cycle N+1.
- Throughput: one instruction per cycle while `out_ready`=1 and there are no hazards.
- Writeback to issue: a dependent instruction may be accepted in the same cycle as the writeback that resolves it, through the forwarding path.
- Back-to-back dependence: with no writeback, the dependent instruction stalls indefinitely. Deadlock avoidance is owned downstream.

## Test plan
- Reset, then wb R1=0x0010, R2=0x0003; issue op=000 rd=3 ra=1 rb=2 instr[3]=0 → next cycle `out_valid`=1, ina=0x0010, inb=0x0003, alu_rd=3, pending[3]=1.
- Immediate: op=010 ra=1, instr[3:0]=4'b1110 → inb=0xFFFE. Logic: op=100, instr[3:0]=4'b0110 → logic_func=4'b0110, inb=R[rb].
- Hazard: issue rd=3, then an instruction with ra=3 → `in_ready`=0 until wb_addr=3 wb_data=0x1234; in that same cycle it is accepted with ina=0x1234.
- Backpressure: hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and outputs unchanged, even across a wb to the source register. Release → one transfer per cycle.
- Same-cycle wb_addr=5 while accepting rd=5 → pending[5]=1 afterward, R[5]=wb_data.
- Assert `rst` while `out_valid`=1 and `pending`≠0 → immediately all outputs 0, `pending`=0, `in_ready`=1.
